// File: rtl/l2cache_req_arbiter_pkg.sv
// Shared encodings for the L2 request arbiter and the L2 request FSM.
package l2cache_req_arbiter_pkg;

    // L2 request source encoding on l2_from.
    localparam logic [1:0] FROM_NONE = 2'b00;
    localparam logic [1:0] FROM_I    = 2'b01;
    localparam logic [1:0] FROM_DR   = 2'b10;
    localparam logic [1:0] FROM_DW   = 2'b11;

    // Arbiter slot states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD_I  = 2'd1,
        ST_HOLD_D  = 2'd2,
        ST_HOLD_OP = 2'd3
    } arb_state_e;

    // Requester bit positions in request / exclusion / winner vectors.
    localparam int unsigned REQ_N  = 3;
    localparam int unsigned REQ_I  = 0;
    localparam int unsigned REQ_D  = 1;
    localparam int unsigned REQ_OP = 2;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned OPCODE_W = 32;

endpackage

// File: rtl/l2_arb_pick.sv
// Fixed-priority picker (cacop > dcache > icache) with icache starvation override.
module l2_arb_pick
    import l2cache_req_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_N-1:0] excl,
    input  logic             starve,
    output logic [REQ_N-1:0] win
);

    logic [REQ_N-1:0] avail;

    assign avail = req & ~excl;

    // One-hot winner among the requesters still eligible this cycle.
    always_comb begin
        win = '0;
        if (avail[REQ_OP]) begin
            win[REQ_OP] = 1'b1;
        end else if (avail[REQ_D] && !(starve && avail[REQ_I])) begin
            win[REQ_D] = 1'b1;
        end else if (avail[REQ_I]) begin
            win[REQ_I] = 1'b1;
        end
    end

endmodule

// File: rtl/l2cache_req_arbiter.sv
// Single-slot arbiter from icache/dcache/cacop onto the shared L2 request port.
module l2cache_req_arbiter
    import l2cache_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_grant,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_suc,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_grant,
    input  logic                  op_req,
    input  logic [OPCODE_W-1:0]   op_code,
    input  logic [ADDR_W-1:0]     op_addr,
    output logic                  op_grant,
    output logic [1:0]            l2_from,
    output logic                  l2_opflag,
    output logic [ADDR_W-1:0]     l2_addr,
    output logic [DATA_W-1:0]     l2_wdata,
    output logic [DATA_W/8-1:0]   l2_wstrb,
    output logic                  l2_suc,
    output logic [OPCODE_W-1:0]   l2_opcode,
    input  logic                  l2_icache_addrOK,
    input  logic                  l2_dcache_addrOK,
    input  logic                  l2_op_ack
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e              state_q, state_d;
    logic [1:0]              from_q, from_d;
    logic                    opflag_q, opflag_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    suc_q, suc_d;
    logic [OPCODE_W-1:0]     opcode_q, opcode_d;
    logic [STARVE_W-1:0]     starve_q, starve_d;

    logic [REQ_N-1:0]        req_vec;
    logic [REQ_N-1:0]        excl;
    logic [REQ_N-1:0]        win;
    logic                    arb_en;
    logic                    starve;

    // Accept events: acknowledges only count when they match the held request.
    assign i_grant  = (state_q == ST_HOLD_I)  && l2_icache_addrOK;
    assign d_grant  = (state_q == ST_HOLD_D)  && l2_dcache_addrOK;
    assign op_grant = (state_q == ST_HOLD_OP) && l2_op_ack;

    // The just-granted requester still shows req this cycle, so it sits out re-arbitration.
    assign excl    = {op_grant, d_grant, i_grant};
    assign arb_en  = (state_q == ST_IDLE) || (|excl);
    assign req_vec = {op_req, d_req, i_req};
    assign starve  = (starve_q == STARVE_W'(STARVE_MAX));

    l2_arb_pick u_pick (
        .req    (req_vec),
        .excl   (excl),
        .starve (starve),
        .win    (win)
    );

    // Next slot state: latch a new winner whenever the slot is free or just accepted.
    always_comb begin
        state_d  = state_q;
        from_d   = from_q;
        opflag_d = opflag_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        suc_d    = suc_q;
        opcode_d = opcode_q;
        if (arb_en) begin
            state_d  = ST_IDLE;
            from_d   = FROM_NONE;
            opflag_d = 1'b0;
            if (win[REQ_OP]) begin
                state_d  = ST_HOLD_OP;
                opflag_d = 1'b1;
                addr_d   = op_addr;
                wdata_d  = '0;
                wstrb_d  = '0;
                suc_d    = 1'b0;
                opcode_d = op_code;
            end else if (win[REQ_D]) begin
                state_d  = ST_HOLD_D;
                from_d   = d_we ? FROM_DW : FROM_DR;
                addr_d   = d_addr;
                wdata_d  = d_wdata;
                wstrb_d  = d_wstrb;
                suc_d    = d_suc;
                opcode_d = '0;
            end else if (win[REQ_I]) begin
                state_d  = ST_HOLD_I;
                from_d   = FROM_I;
                addr_d   = i_addr;
                wdata_d  = '0;
                wstrb_d  = '0;
                suc_d    = 1'b0;
                opcode_d = '0;
            end
        end
    end

    // Count dcache wins that overtook a waiting icache request.
    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_grant) begin
            starve_d = '0;
        end else if (d_grant && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Slot, payload and starvation counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            from_q   <= FROM_NONE;
            opflag_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            suc_q    <= 1'b0;
            opcode_q <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            from_q   <= from_d;
            opflag_q <= opflag_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            suc_q    <= suc_d;
            opcode_q <= opcode_d;
            starve_q <= starve_d;
        end
    end

    assign l2_from   = from_q;
    assign l2_opflag = opflag_q;
    assign l2_addr   = addr_q;
    assign l2_wdata  = wdata_q;
    assign l2_wstrb  = wstrb_q;
    assign l2_suc    = suc_q;
    assign l2_opcode = opcode_q;

endmodule
